spi_ram_burst: RTL and testbench

- Parametrised successor to the SPI-slave-facing single-port RAM. Takes (DATA_WIDTH+2)-bit command words from the SPI slave and returns read data words.
- Adds generic data width, auto-incrementing burst addresses with wrap-around, and a sticky protocol-error flag.
- Optional power-on memory clear sweep.
- Sits between spi_slave and the wrapper top, on the same clk.

---
 rtl/spi_ram_pkg.sv | 21 ++
 rtl/spi_ram_burst_mem.sv | 46 ++++
 rtl/spi_ram_burst.sv | 155 +++++++++++++++
 tb/tb_spi_ram_burst.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// Shared command encoding, FSM state type and address helper for the SPI-facing burst RAM.
package spi_ram_pkg;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    // Increment with wrap at depth-1; callers truncate to their address width.
    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [31:0] depth);
        return (addr == depth - 32'd1) ? 32'd0 : addr + 32'd1;
    endfunction

endpackage

// File: rtl/spi_ram_burst_mem.sv
// Single-port-style 1R1W storage array with a registered, holding read port.
module spi_ram_mem
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH  = 256,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_SIZE  = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_SIZE-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_SIZE-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    // Array contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/spi_ram_burst.sv
// Command decode, burst pointers, sticky error and optional power-on clear (SPI_RAM_CLEAR_EN)
// in front of the spi_ram_mem storage array.
module spi_ram_burst
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH  = 256,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_valid,
    input  logic [DATA_WIDTH+1:0] rx_data,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  busy,
    output logic                  err
);

    localparam int          ADDR_SIZE = $clog2(MEM_DEPTH);
    localparam logic [31:0] DEPTH_W   = 32'(MEM_DEPTH);

    logic [ADDR_SIZE-1:0]  wr_addr_q, wr_addr_d;
    logic [ADDR_SIZE-1:0]  rd_addr_q, rd_addr_d;
    logic                  rd_armed_q, rd_armed_d;
    logic                  err_q, err_d;
    logic                  tx_valid_q, tx_valid_d;

    logic                  mem_we, mem_re;
    logic [ADDR_SIZE-1:0]  mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    logic [1:0]            cmd;
    logic [DATA_WIDTH-1:0] payload;
    logic                  addr_hi_set;

    assign cmd         = rx_data[DATA_WIDTH+1:DATA_WIDTH];
    assign payload     = rx_data[DATA_WIDTH-1:0];
    // Address commands still take the low bits even when upper payload bits flag an error.
    assign addr_hi_set = |(payload >> ADDR_SIZE);

`ifdef SPI_RAM_CLEAR_EN
    localparam logic [0:0]           S_IDLE    = IDLE;
    localparam logic [0:0]           S_CLEAR   = CLEAR;
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

    logic [0:0]           state_q, state_d;
    logic [ADDR_SIZE-1:0] clr_cnt_q, clr_cnt_d;

    assign busy = (state_q == S_CLEAR);
`else
    assign busy = 1'b0;
`endif

    always_comb begin
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        rd_armed_d = rd_armed_q;
        err_d      = err_q;
        tx_valid_d = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_waddr  = wr_addr_q;
        mem_wdata  = payload;
`ifdef SPI_RAM_CLEAR_EN
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        if (state_q == S_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q;
            mem_wdata = '0;
            clr_cnt_d = ADDR_SIZE'(next_addr(32'(clr_cnt_q), DEPTH_W));
            if (clr_cnt_q == LAST_ADDR) begin
                state_d = S_IDLE;
            end
            if (rx_valid) begin
                err_d = 1'b1;
            end
        end else
`endif
        if (rx_valid) begin
            case (cmd_e'(cmd))
                WR_ADDR: begin
                    wr_addr_d = payload[ADDR_SIZE-1:0];
                    if (addr_hi_set) err_d = 1'b1;
                end
                WR_DATA: begin
                    mem_we    = 1'b1;
                    wr_addr_d = ADDR_SIZE'(next_addr(32'(wr_addr_q), DEPTH_W));
                end
                RD_ADDR: begin
                    rd_addr_d  = payload[ADDR_SIZE-1:0];
                    rd_armed_d = 1'b1;
                    if (addr_hi_set) err_d = 1'b1;
                end
                RD_DATA: begin
                    if (rd_armed_q) begin
                        mem_re     = 1'b1;
                        tx_valid_d = 1'b1;
                        rd_addr_d  = ADDR_SIZE'(next_addr(32'(rd_addr_q), DEPTH_W));
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            rd_armed_q <= 1'b0;
            err_q      <= 1'b0;
            tx_valid_q <= 1'b0;
        end else begin
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            rd_armed_q <= rd_armed_d;
            err_q      <= err_d;
            tx_valid_q <= tx_valid_d;
        end
    end

`ifdef SPI_RAM_CLEAR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end
`endif

    spi_ram_mem #(
        .MEM_DEPTH (MEM_DEPTH),
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_mem (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (mem_we),
        .waddr(mem_waddr),
        .wdata(mem_wdata),
        .re   (mem_re),
        .raddr(rd_addr_q),
        .rdata(tx_data)
    );

    assign tx_valid = tx_valid_q;
    assign err      = err_q;

endmodule

// File: tb/tb_spi_ram_burst.sv
// Scoreboard bench for spi_ram_burst: default 256x8 instance plus a 64x16 instance.
module tb_spi_ram_burst;

    localparam logic [1:0] C_WR_ADDR = 2'b00;
    localparam logic [1:0] C_WR_DATA = 2'b01;
    localparam logic [1:0] C_RD_ADDR = 2'b10;
    localparam logic [1:0] C_RD_DATA = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_valid;
    logic [9:0]  rx_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        busy;
    logic        err;

    logic        rx_valid16;
    logic [17:0] rx_data16;
    logic        tx_valid16;
    logic [15:0] tx_data16;
    logic        busy16;
    logic        err16;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  exp_q[$];
    logic [15:0] exp16_q[$];

    always #5 clk = ~clk;

    spi_ram_burst dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .busy(busy), .err(err)
    );

    spi_ram_burst #(.MEM_DEPTH(64), .DATA_WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid16), .rx_data(rx_data16),
        .tx_valid(tx_valid16), .tx_data(tx_data16), .busy(busy16), .err(err16)
    );

    // Read-data scoreboards: every tx_valid pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (tx_valid === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL tx_unexpected: got tx_valid=1 tx_data=%h, expected no pulse", tx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (tx_data !== e) begin
                    n_err++;
                    $display("FAIL tx_data: got %h expected %h", tx_data, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (tx_valid16 === 1'b1) begin
            n_cmp++;
            if (exp16_q.size() == 0) begin
                n_err++;
                $display("FAIL tx16_unexpected: got tx_valid=1 tx_data=%h, expected no pulse", tx_data16);
            end else begin
                logic [15:0] e;
                e = exp16_q.pop_front();
                if (tx_data16 !== e) begin
                    n_err++;
                    $display("FAIL tx16_data: got %h expected %h", tx_data16, e);
                end
            end
        end
    end

    task automatic send(input logic [1:0] c, input logic [7:0] p);
        rx_valid = 1'b1;
        rx_data  = {c, p};
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send16(input logic [1:0] c, input logic [15:0] p);
        rx_valid16 = 1'b1;
        rx_data16  = {c, p};
        @(posedge clk);
        #1;
        rx_valid16 = 1'b0;
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while ((busy !== 1'b0 || busy16 !== 1'b0) && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        n_cmp++;
        if (busy !== 1'b0 || busy16 !== 1'b0) begin
            n_err++;
            $display("FAIL wait_idle: got busy=%b busy16=%b expected 0 within 2000 cycles", busy, busy16);
        end
    endtask

    task automatic test_reset();
        logic exp_busy;
`ifdef SPI_RAM_CLEAR_EN
        exp_busy = 1'b1;
`else
        exp_busy = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (tx_valid !== 1'b0)   begin n_err++; $display("FAIL rst_tx_valid: got %b expected 0", tx_valid); end
        n_cmp++; if (tx_data !== 8'h00)   begin n_err++; $display("FAIL rst_tx_data: got %h expected 00", tx_data); end
        n_cmp++; if (err !== 1'b0)        begin n_err++; $display("FAIL rst_err: got %b expected 0", err); end
        n_cmp++; if (busy !== exp_busy)   begin n_err++; $display("FAIL rst_busy: got %b expected %b", busy, exp_busy); end
        n_cmp++; if (err16 !== 1'b0)      begin n_err++; $display("FAIL rst_err16: got %b expected 0", err16); end
        n_cmp++; if (tx_data16 !== 16'h0) begin n_err++; $display("FAIL rst_tx_data16: got %h expected 0000", tx_data16); end
        rst_n = 1'b1;
    endtask

`ifdef SPI_RAM_CLEAR_EN
    task automatic test_clear_sweep();
        int hi = 0;
        int guard = 0;
        while (guard < 2000) begin
            @(negedge clk);
            guard++;
            if (busy !== 1'b1) break;
            hi++;
            if (hi == 10) begin
                rx_valid = 1'b1;
                rx_data  = {C_WR_DATA, 8'h5A};
            end else begin
                rx_valid = 1'b0;
            end
        end
        rx_valid = 1'b0;
        n_cmp++; if (hi != 256)    begin n_err++; $display("FAIL clear_busy_cycles: got %0d expected 256", hi); end
        n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL clear_drop_err: got %b expected 1", err); end
        wait_idle();
    endtask

    task automatic test_clear_readback();
        send(C_RD_ADDR, 8'h80);
        exp_q.push_back(8'h00);
        send(C_RD_DATA, 8'h00);
        n_cmp++; if (tx_valid !== 1'b1) begin n_err++; $display("FAIL clear_rd_valid: got %b expected 1", tx_valid); end
    endtask
`endif

    task automatic test_unarmed();
        send(C_RD_DATA, 8'h00);
        n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL unarmed_tx_valid: got %b expected 0", tx_valid); end
        n_cmp++; if (err !== 1'b1)      begin n_err++; $display("FAIL unarmed_err: got %b expected 1", err); end
    endtask

    task automatic test_burst();
        logic [7:0] wdat [3];
        wdat[0] = 8'hA1; wdat[1] = 8'hA2; wdat[2] = 8'hA3;
        send(C_WR_ADDR, 8'h10);
        for (int i = 0; i < 3; i++) send(C_WR_DATA, wdat[i]);
        send(C_RD_ADDR, 8'h10);
        for (int i = 0; i < 3; i++) exp_q.push_back(wdat[i]);
        for (int i = 0; i < 3; i++) begin
            send(C_RD_DATA, 8'($urandom_range(0, 255)));
            n_cmp++;
            if (tx_valid !== 1'b1) begin n_err++; $display("FAIL burst_latency%0d: got tx_valid=%b expected 1", i, tx_valid); end
        end
        @(posedge clk);
        #1;
        n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL burst_pulse_end: got %b expected 0", tx_valid); end
        n_cmp++; if (tx_data !== 8'hA3) begin n_err++; $display("FAIL burst_hold: got %h expected a3", tx_data); end
    endtask

    task automatic test_wrap();
        send(C_WR_ADDR, 8'hFF);
        send(C_WR_DATA, 8'h11);
        send(C_WR_DATA, 8'h22);
        send(C_RD_ADDR, 8'hFF);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send(C_RD_DATA, 8'h00);
        send(C_RD_DATA, 8'h00);
        @(posedge clk);
        #1;
        n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b expected 1", err); end
    endtask

    task automatic test_reset_mid_burst();
        send(C_RD_ADDR, 8'h05);
        rx_valid = 1'b1;
        rx_data  = {C_RD_DATA, 8'h00};
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL midrst_tx_valid: got %b expected 0", tx_valid); end
        n_cmp++; if (err !== 1'b0)      begin n_err++; $display("FAIL midrst_err: got %b expected 0", err); end
        n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL midrst_tx_data: got %h expected 00", tx_data); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_idle();
        send(C_RD_DATA, 8'h00);
        n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL midrst_disarm_valid: got %b expected 0", tx_valid); end
        n_cmp++; if (err !== 1'b1)      begin n_err++; $display("FAIL midrst_disarm_err: got %b expected 1", err); end
    endtask

    task automatic test_wide();
        n_cmp++; if (err16 !== 1'b0) begin n_err++; $display("FAIL wide_err_init: got %b expected 0", err16); end
        send16(C_WR_ADDR, 16'h0105);
        n_cmp++; if (err16 !== 1'b1) begin n_err++; $display("FAIL wide_addr_err: got %b expected 1", err16); end
        send16(C_WR_DATA, 16'hBEEF);
        send16(C_WR_ADDR, 16'h003F);
        send16(C_WR_DATA, 16'h1234);
        send16(C_WR_DATA, 16'h5678);
        send16(C_RD_ADDR, 16'h0005);
        exp16_q.push_back(16'hBEEF);
        send16(C_RD_DATA, 16'hFFFF);
        n_cmp++; if (tx_valid16 !== 1'b1) begin n_err++; $display("FAIL wide_rd_valid: got %b expected 1", tx_valid16); end
        send16(C_RD_ADDR, 16'h003F);
        exp16_q.push_back(16'h1234);
        exp16_q.push_back(16'h5678);
        send16(C_RD_DATA, 16'h0000);
        send16(C_RD_DATA, 16'h0000);
    endtask

    initial begin
        rst_n      = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = '0;
        rx_valid16 = 1'b0;
        rx_data16  = '0;
        test_reset();
`ifdef SPI_RAM_CLEAR_EN
        test_clear_sweep();
`endif
        wait_idle();
        test_unarmed();
`ifdef SPI_RAM_CLEAR_EN
        test_clear_readback();
`endif
        test_burst();
        test_wrap();
        test_reset_mid_burst();
        test_wide();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (exp_q.size() != 0)   begin n_err++; $display("FAIL missing_tx: got %0d outstanding expected 0", exp_q.size()); end
        n_cmp++; if (exp16_q.size() != 0) begin n_err++; $display("FAIL missing_tx16: got %0d outstanding expected 0", exp16_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
